// File: rtl/spi_sample_averager_pkg.sv
// -----------------------------------------------------------------------------
// spi_sample_averager_pkg
//   Shared definitions for the SPI sample averager and its window datapath.
//   Holds the SPI word width, the default window size exponent and the
//   encoding of the one-deep output buffer state.
// -----------------------------------------------------------------------------
package spi_sample_averager_pkg;

    // Width of one SPI receive word.
    localparam int SPI_WORD_W     = 12;

    // Default window length exponent: N = 2**DEFAULT_LOG2_N samples.
    localparam int DEFAULT_LOG2_N = 3;

    // Output buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/spi_avg_window.sv
// -----------------------------------------------------------------------------
// spi_avg_window
//   Accumulate / min / max datapath for one window of 2**LOG2_N samples.
//   Raises a single-cycle `done` in the same cycle as the completing sample
//   and presents the window result combinationally on res_* during that
//   cycle, so the caller can register it on the same edge.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clear     in   abort the partial window (wins over in_valid)
//   in_data   in   DATA_WIDTH unsigned sample
//   in_valid  in   sample strobe, accepted every cycle it is high
//   done      out  window completes on this cycle's accepted sample
//   res_mean  out  (acc + in_data) >> LOG2_N, truncated
//   res_min   out  smallest sample including the completing one
//   res_max   out  largest sample including the completing one
//   fill      out  samples accepted so far in the current window
// -----------------------------------------------------------------------------
module spi_avg_window
    import spi_sample_averager_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_WORD_W,
    parameter int LOG2_N     = DEFAULT_LOG2_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] res_mean,
    output logic [DATA_WIDTH-1:0] res_min,
    output logic [DATA_WIDTH-1:0] res_max,
    output logic [LOG2_N-1:0]     fill
);

    // Sum of N DATA_WIDTH samples fits in DATA_WIDTH+LOG2_N bits.
    localparam int                ACC_W     = DATA_WIDTH + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_FILL = '1;

    logic [ACC_W-1:0]      r_acc;
    logic [DATA_WIDTH-1:0] r_min;
    logic [DATA_WIDTH-1:0] r_max;
    logic [LOG2_N-1:0]     r_fill;

    logic                  w_accept;
    logic                  w_done;
    logic [ACC_W-1:0]      w_sum;
    logic [DATA_WIDTH-1:0] w_min;
    logic [DATA_WIDTH-1:0] w_max;

    // Truncating divide by N; the shifted sum always fits DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] mean_trunc(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] shifted;
        shifted = sum >> LOG2_N;
        return shifted[DATA_WIDTH-1:0];
    endfunction

    // clear discards the sample presented with it.
    assign w_accept = in_valid && !clear;
    assign w_done   = w_accept && (r_fill == LAST_FILL);

    // Running values including the sample on the input this cycle.
    assign w_sum = r_acc + ACC_W'(in_data);
    assign w_min = (in_data < r_min) ? in_data : r_min;
    assign w_max = (in_data > r_max) ? in_data : r_max;

    // ---- window state register ------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc  <= '0;
            r_min  <= '1;
            r_max  <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            if (w_done) begin
                r_acc  <= '0;
                r_min  <= '1;
                r_max  <= '0;
                r_fill <= '0;
            end else begin
                r_acc  <= w_sum;
                r_min  <= w_min;
                r_max  <= w_max;
                r_fill <= r_fill + LOG2_N'(1);
            end
        end
    end

    assign done     = w_done;
    assign res_mean = mean_trunc(w_sum);
    assign res_min  = w_min;
    assign res_max  = w_max;
    assign fill     = r_fill;

endmodule

// File: rtl/spi_sample_averager.sv
// -----------------------------------------------------------------------------
// spi_sample_averager
//   Averages fixed windows of 2**LOG2_N SPI receive words and offers the
//   mean/min/max of each window through a one-deep valid/ready buffer.
//   A window completing while the buffer is full and the sink is not
//   accepting is dropped and flagged on the sticky `overrun`.
//
// Ports
//   clk        in   system clock (shared with the SPI master)
//   rst        in   synchronous active-high reset, clears everything
//   clear      in   abort partial window and clear overrun; buffer untouched
//   in_data    in   DATA_WIDTH unsigned sample
//   in_valid   in   sample strobe, no backpressure
//   out_mean   out  window mean, truncated
//   out_min    out  window minimum
//   out_max    out  window maximum
//   out_valid  out  output buffer holds a result
//   out_ready  in   sink accepts; transfer on out_valid & out_ready
//   overrun    out  sticky, a completed window was dropped
//   fill       out  samples accepted so far in the current window
// -----------------------------------------------------------------------------
module spi_sample_averager
    import spi_sample_averager_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_WORD_W,
    parameter int LOG2_N     = DEFAULT_LOG2_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_mean,
    output logic [DATA_WIDTH-1:0] out_min,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic [LOG2_N-1:0]     fill
);

    buf_state_t            r_state;
    buf_state_t            w_state_nxt;
    logic                  w_load;
    logic                  w_drop;

    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_res_mean;
    logic [DATA_WIDTH-1:0] w_res_min;
    logic [DATA_WIDTH-1:0] w_res_max;

    logic [DATA_WIDTH-1:0] r_mean;
    logic [DATA_WIDTH-1:0] r_min;
    logic [DATA_WIDTH-1:0] r_max;
    logic                  r_overrun;

    spi_avg_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_N     (LOG2_N)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .done     (w_done),
        .res_mean (w_res_mean),
        .res_min  (w_res_min),
        .res_max  (w_res_max),
        .fill     (fill)
    );

    // Buffer next state. A completion while full is only loaded if the
    // current contents leave on the same edge; otherwise it is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (w_done) begin
                    if (out_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (out_ready) begin
                    w_state_nxt = BUF_EMPTY;
                end
            end
            default: begin
                w_state_nxt = BUF_EMPTY;
            end
        endcase
    end

    // ---- output buffer register -----------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
            r_mean  <= '0;
            r_min   <= '0;
            r_max   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_mean <= w_res_mean;
                r_min  <= w_res_min;
                r_max  <= w_res_max;
            end
        end
    end

    // clear and a drop cannot coincide: clear suppresses completion.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign out_valid = (r_state == BUF_FULL);
    assign out_mean  = r_mean;
    assign out_min   = r_min;
    assign out_max   = r_max;
    assign overrun   = r_overrun;

endmodule
